// File: rtl/mux_ctrl_pkg.sv
// Shared types and defaults for the mux select controller.
// The state encoding lives here so the bench and future blocks agree on it.
package mux_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SELECTED = 2'd1,
        ST_OVERRIDE = 2'd2
    } state_e;

    localparam int DEFAULT_OVERRIDE_CODE = 5;

    // Code 0 is reserved for "none", so codes 1..N_BUTTONS must fit in SEL_W bits.
    function automatic bit sel_w_ok(input int sel_w, input int n_buttons);
        return (1 << sel_w) > n_buttons;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One button lane: 2-flop synchronizer followed by a stable-sample counter.
// The counter exists only when MUX_CTRL_DEBOUNCE_EN is defined; otherwise the level passes straight through.
module button_debounce
`ifdef MUX_CTRL_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 4
)
`endif
(
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic level_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], raw_i};
    end

`ifdef MUX_CTRL_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    // Any sample back at the accepted level clears the count, so bounces never accumulate.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) level_d = sync_q[1];
            else                   cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
`else
    assign level_o = sync_q[1];
`endif

endmodule

// File: rtl/mux_select_ctrl.sv
// Latched button-to-mux-select controller with a slide-switch override.
// Button debouncing is enabled by defining MUX_CTRL_DEBOUNCE_EN.
module mux_select_ctrl
    import mux_ctrl_pkg::*;
#(
    parameter int N_BUTTONS       = 5,
    parameter int SEL_W           = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int OVERRIDE_CODE   = DEFAULT_OVERRIDE_CODE
)(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] buttons,
    input  logic                 switch,
    output logic [SEL_W-1:0]     sel,
    output logic                 sel_valid,
    output logic                 override,
    output logic                 press_pulse
);

    if (!sel_w_ok(SEL_W, N_BUTTONS)) begin : g_bad_sel_w
        $error("SEL_W too narrow for N_BUTTONS");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [N_BUTTONS-1:0] level;
    logic [N_BUTTONS-1:0] prev_q;
    logic [N_BUTTONS-1:0] press_edge;
    logic [1:0]           sw_sync_q;

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_btn
        button_debounce
`ifdef MUX_CTRL_DEBOUNCE_EN
            #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
            u_db (
                .clock   (clock),
                .reset   (reset),
                .raw_i   (buttons[g]),
                .level_o (level[g])
            );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sw_sync_q <= '0;
            prev_q    <= '0;
        end else begin
            sw_sync_q <= {sw_sync_q[0], switch};
            prev_q    <= level;
        end
    end

    assign press_edge = level & ~prev_q;

    // Ascending scan: the last hit, i.e. the highest index, wins.
    function automatic logic [SEL_W-1:0] pick_code(input logic [N_BUTTONS-1:0] e);
        pick_code = '0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            if (e[i]) pick_code = SEL_W'(i + 1);
        end
    endfunction

    state_e           state_q, state_d;
    logic [SEL_W-1:0] latch_q, latch_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             vld_q, vld_d, ovr_q, ovr_d, pulse_q, pulse_d;

    always_comb begin
        state_d = state_q;
        latch_d = latch_q;
        pulse_d = 1'b0;
        sel_d   = '0;
        vld_d   = 1'b0;
        ovr_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_SELECTED: begin
                if (sw_sync_q[1]) begin
                    state_d = ST_OVERRIDE;
                end else if (|press_edge) begin
                    state_d = ST_SELECTED;
                    latch_d = pick_code(press_edge);
                    pulse_d = 1'b1;
                end
            end
            ST_OVERRIDE: begin
                if (!sw_sync_q[1]) state_d = (latch_q != '0) ? ST_SELECTED : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs follow the next state so they land on the same edge as the state register.
        case (state_d)
            ST_SELECTED: begin
                sel_d = latch_d;
                vld_d = 1'b1;
            end
            ST_OVERRIDE: begin
                sel_d = SEL_W'(OVERRIDE_CODE);
                vld_d = 1'b1;
                ovr_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            latch_q <= '0;
            sel_q   <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
            pulse_q <= pulse_d;
        end
    end

    assign sel         = sel_q;
    assign sel_valid   = vld_q;
    assign override    = ovr_q;
    assign press_pulse = pulse_q;

endmodule

// File: tb/tb_mux_select_ctrl.sv
// Directed bench for mux_select_ctrl at default parameters.
// Expected button latency follows MUX_CTRL_DEBOUNCE_EN: 3 + DEBOUNCE_CYCLES edges when defined, 3 otherwise.
module tb_mux_select_ctrl;

    localparam int N_BUTTONS       = 5;
    localparam int SEL_W           = 3;
    localparam int DEBOUNCE_CYCLES = 4;
`ifdef MUX_CTRL_DEBOUNCE_EN
    localparam int LAT = 3 + DEBOUNCE_CYCLES;
`else
    localparam int LAT = 3;
`endif

    logic                 clock;
    logic                 reset;
    logic [N_BUTTONS-1:0] buttons;
    logic                 switch;
    logic [SEL_W-1:0]     sel;
    logic                 sel_valid;
    logic                 override;
    logic                 press_pulse;

    int vectors;
    int miscompares;

    mux_select_ctrl #(
        .N_BUTTONS       (N_BUTTONS),
        .SEL_W           (SEL_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .OVERRIDE_CODE   (5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .buttons     (buttons),
        .switch      (switch),
        .sel         (sel),
        .sel_valid   (sel_valid),
        .override    (override),
        .press_pulse (press_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all(input string tag, input int e_sel, input int e_vld,
                           input int e_ovr, input int e_pulse);
        chk({tag, ".sel"},         32'(sel),         32'(e_sel));
        chk({tag, ".sel_valid"},   32'(sel_valid),   32'(e_vld));
        chk({tag, ".override"},    32'(override),    32'(e_ovr));
        chk({tag, ".press_pulse"}, 32'(press_pulse), 32'(e_pulse));
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int e_sel;
        int e_pulse;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        buttons     = '0;
        switch      = 1'b0;
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0);
        reset = 1'b0;

        for (int t = 1; t <= 20; t++) begin
            tick();
            chk_all($sformatf("idle[%0d]", t), 0, 0, 0, 0);
        end

        // Button 2 held for 10 cycles, then released.
        buttons = 5'b00100;
        for (int t = 1; t <= 10; t++) begin
            tick();
            chk_all($sformatf("btn2[%0d]", t), (t >= LAT) ? 3 : 0, (t >= LAT) ? 1 : 0, 0,
                    (t == LAT) ? 1 : 0);
        end
        buttons = '0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            chk_all($sformatf("btn2_rel[%0d]", t), 3, 1, 0, 0);
        end

        // Button 1 bounces 1,0,1,0 then holds.
        for (int t = 1; t <= 16; t++) begin
            buttons = (t == 1 || t == 3 || t >= 5) ? 5'b00010 : 5'b00000;
            tick();
`ifdef MUX_CTRL_DEBOUNCE_EN
            e_sel   = (t >= 11) ? 2 : 3;
            e_pulse = (t == 11) ? 1 : 0;
`else
            e_sel   = (t >= 3) ? 2 : 3;
            e_pulse = (t == 3 || t == 5 || t == 7) ? 1 : 0;
`endif
            chk_all($sformatf("bounce[%0d]", t), e_sel, 1, 0, e_pulse);
        end
        buttons = '0;
        settle(12);
        chk_all("bounce_rel", 2, 1, 0, 0);

        // Buttons 0 and 4 together: highest index wins.
        buttons = 5'b10001;
        for (int t = 1; t <= LAT + 2; t++) begin
            tick();
            chk_all($sformatf("dual[%0d]", t), (t >= LAT) ? 5 : 2, 1, 0, (t == LAT) ? 1 : 0);
        end
        buttons = '0;
        settle(12);

        // Back to sel=3, then override round trip.
        buttons = 5'b00100;
        for (int t = 1; t <= LAT + 1; t++) begin
            tick();
            chk_all($sformatf("btn2b[%0d]", t), (t >= LAT) ? 3 : 5, 1, 0, (t == LAT) ? 1 : 0);
        end
        buttons = '0;
        settle(12);
        switch = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            tick();
            chk_all($sformatf("sw_up[%0d]", t), (t == 3) ? 5 : 3, 1, (t == 3) ? 1 : 0, 0);
        end
        buttons = 5'b00001;
        for (int t = 1; t <= LAT + 3; t++) begin
            tick();
            chk_all($sformatf("ovr_btn0[%0d]", t), 5, 1, 1, 0);
        end
        buttons = '0;
        settle(12);
        switch = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            tick();
            chk_all($sformatf("sw_dn[%0d]", t), (t == 3) ? 3 : 5, 1, (t < 3) ? 1 : 0, 0);
        end
        tick();
        chk_all("sw_dn_hold", 3, 1, 0, 0);

        // Switch rise on the same edge as an accepted press of button 1.
        reset = 1'b1;
        tick();
        chk_all("reset2", 0, 0, 0, 0);
        reset   = 1'b0;
        buttons = 5'b00010;
        for (int t = 1; t <= LAT - 3; t++) begin
            tick();
            chk_all($sformatf("coin_pre[%0d]", t), 0, 0, 0, 0);
        end
        switch = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk_all($sformatf("coin[%0d]", t), (t >= 3) ? 5 : 0, (t >= 3) ? 1 : 0,
                    (t >= 3) ? 1 : 0, 0);
        end
        buttons = '0;
        settle(12);
        switch = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            tick();
            chk_all($sformatf("coin_dn[%0d]", t), (t >= 3) ? 0 : 5, (t >= 3) ? 0 : 1,
                    (t >= 3) ? 0 : 1, 0);
        end

        // Reset while in override with a debounce in progress.
        buttons = 5'b01000;
        for (int t = 1; t <= LAT; t++) begin
            tick();
            chk_all($sformatf("btn3[%0d]", t), (t == LAT) ? 4 : 0, (t == LAT) ? 1 : 0, 0,
                    (t == LAT) ? 1 : 0);
        end
        switch = 1'b1;
        settle(3);
        chk_all("ovr_pre_rst", 5, 1, 1, 0);
        buttons = 5'b01001;
        settle(2);
        reset   = 1'b1;
        switch  = 1'b0;
        buttons = 5'b01000;
        tick();
        chk_all("mid_rst", 0, 0, 0, 0);
        reset = 1'b0;
        for (int t = 1; t <= LAT + 1; t++) begin
            tick();
            chk_all($sformatf("post_rst[%0d]", t), (t >= LAT) ? 4 : 0, (t >= LAT) ? 1 : 0, 0,
                    (t == LAT) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_select_ctrl.md
# mux_select_ctrl

Parametrised selection controller driving the display/data mux select. It turns N debounced push-buttons into a latched, one-hot-free select code and gives a slide switch priority as an override that forces a fixed code. When the switch is released, the last button selection is restored. It sits between the board I/O pins and the mux select input, replacing the fixed 5-button, unlatched controller.

## Interface
- N_BUTTONS, 5, number of button inputs (1..15)
- SEL_W, 3, select width; must satisfy 2**SEL_W > N_BUTTONS
- DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a button level (>=1)
- OVERRIDE_CODE, 5, select code driven while override is active

Ports:
- clock  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- buttons  in  N_BUTTONS  raw asynchronous button levels, 1 = pressed
- switch  in  1  raw asynchronous override switch, 1 = override
- sel  out  SEL_W  mux select code
- sel_valid  out  1  high when sel carries a real selection (SELECTED or OVERRIDE)
- override  out  1  high while in OVERRIDE
- press_pulse  out  1  one-cycle strobe when a button press is accepted and latched

## Operation
- buttons and switch each pass through a 2-flop synchronizer. The switch is never debounced.
- Each synchronized button is debounced. The accepted level changes only after DEBOUNCE_CYCLES consecutive samples at the new level.
- Press edge = accepted level 0->1. Releases are ignored.
- Multiple press edges in one cycle: the highest index wins. Code = index+1, so button 0 -> 1 and code 0 means "none".
- State machine (encoding in package):
  - IDLE: sel=0, sel_valid=0, override=0. Press edge -> SELECTED, latch code. Switch sync=1 -> OVERRIDE.
  - SELECTED: sel=latched code, sel_valid=1. Press edge -> relatch code and stay in SELECTED. Switch sync=1 -> OVERRIDE.
  - OVERRIDE: sel=OVERRIDE_CODE, sel_valid=1, override=1. Press edges are discarded and do not update the latch. Switch sync=0 -> SELECTED if a code was latched before entry, else IDLE.
- Simultaneous press edge and switch 0->1 in the same cycle: override wins and the press is discarded. press_pulse stays 0.
- Debounce and edge-detect state keeps tracking during OVERRIDE. A button held across the switch release produces no edge and no change.
- press_pulse is asserted only when a code is actually latched.
- Reset (any time, including mid-debounce or in OVERRIDE):
  - sel=0, sel_valid=0, override=0, press_pulse=0.
  - State = IDLE, latch = 0.
  - Synchronizers, accepted levels and debounce counters = 0.

## Timing
- Switch: override and sel change on the 3rd rising edge after the edge that first samples the new switch level. This is 2 sync stages plus the state register.
- Button, debounced: sel and press_pulse update on the (3 + DEBOUNCE_CYCLES)th edge after first sampling a stable new level.
- A bounce that returns before the count completes resets the counter; no edge is produced.
- Outputs are registered; there is no combinational path from inputs to outputs.
- press_pulse is high for exactly one cycle per accepted press.

## Configuration
- MUX_CTRL_DEBOUNCE_EN defined: debounce counters are instantiated as described.
- Undefined: the accepted level equals the synchronized level. Button latency becomes 3 edges, DEBOUNCE_CYCLES is ignored, and no counter logic is present.

## Structure
- Package mux_ctrl_pkg holds:
  - state enum IDLE/SELECTED/OVERRIDE (2 bits)
  - default OVERRIDE_CODE
  - a function checking SEL_W against N_BUTTONS
- Sub-module button_debounce: one synchronizer plus counter per bit, instantiated N_BUTTONS times via generate. Its counter is compiled out with the macro.
- The top level holds the switch synchronizer, edge detect, priority select, state machine and output registers.

## Test plan
- Reset, then idle 20 cycles: sel=0, sel_valid=0, override=0, press_pulse=0 throughout.
- Hold button 2 for 10 cycles (defaults, debounce on): sel=3 and one press_pulse on the 7th edge after first sample. Release: sel stays 3.
- Button 1 bouncing 1,0,1,0 at 1-cycle intervals, then held: no press_pulse until 4 stable samples. Then sel=2.
- Buttons 0 and 4 pressed in the same cycle: sel=5, with exactly one press_pulse.
- From sel=3, raise switch: sel=5 and override=1 after 3 edges. Press button 0 during override: no change. Drop switch: sel=3.
- Switch rise coincident with an accepted press of button 1: OVERRIDE, no press_pulse. Switch fall returns to IDLE with sel=0. Assert reset mid-debounce: all outputs 0 next edge.
